keypad_digit_entry: RTL and testbench
=====================================

Name: keypad_digit_entry

Overview:
- Sits directly downstream of the one-hot-to-BCD keypad converter. Consumes its 4-bit digit code Bin and any-key flag CHK.
- Synchronizes and debounces each key press, then shifts accepted digits into an N-digit BCD entry buffer.
- Commits the buffered number on an ENTER strobe. Downstream logic (nap-timer setpoint) reads the committed value.

Parameters:
NUM_DIGITS, 4, number of BCD digits held in the entry buffer (1..8)
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a press or release (2..65535)

Ports:
CLK  input  1  system clock
RST_N  input  1  reset, asynchronous assert, active-low
Bin  input  4  digit code from converter (asynchronous to CLK)
CHK  input  1  any-key-pressed flag from converter (asynchronous to CLK)
CLR  input  1  synchronous single-cycle clear request
ENTER  input  1  synchronous single-cycle commit request
Digits  output  4*NUM_DIGITS  live entry buffer; [3:0] = most recent digit
Count  output  clog2(NUM_DIGITS+1)  number of valid digits in buffer
Value  output  4*NUM_DIGITS  last committed number, same BCD layout as Digits
Key_valid  output  1  one-cycle pulse per accepted digit
Commit_valid  output  1  one-cycle pulse when Value updates
Overflow  output  1  sticky: a digit was shifted out of a full buffer
Err  output  1  one-cycle pulse: debounced press carried code >9

Behaviour:
- Clock and reset: one clock CLK. Reset is asynchronous, active-low (RST_N).
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; counters and synchronizers are 0.
- Synchronizer: CHK and Bin each pass through 2 flops. The FSM uses only the synchronized copies (chk_s, bin_s).
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: when chk_s=1, latch bin_s into key_reg, set db_cnt=1, go to PRESS_DB.
  - PRESS_DB:
    - If chk_s=0 or bin_s!=key_reg, go to IDLE (bounce rejected, no output).
    - Otherwise db_cnt++.
    - When db_cnt reaches DEBOUNCE_CYCLES, accept and go to HELD.
  - HELD: when chk_s=0, set db_cnt=1 and go to RELEASE_DB. Changes on Bin while held are ignored; there is no auto-repeat.
  - RELEASE_DB:
    - If chk_s=1, go to HELD.
    - Otherwise db_cnt++.
    - When db_cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- Latency: let edge k be the first CLK edge sampling raw CHK=1 with the key held stable.
  - FSM enters PRESS_DB at edge k+2.
  - Accept occurs at edge k+1+DEBOUNCE_CYCLES.
  - Key_valid is high for the following cycle.
- Accept action:
  - key_reg <= 9: shift Digits left by 4, insert key_reg at [3:0], pulse Key_valid.
    - If Count<NUM_DIGITS, Count++.
    - Otherwise the top digit is discarded, Count stays NUM_DIGITS, and Overflow is set.
  - key_reg > 9: buffer unchanged; pulse Err, not Key_valid.
- ENTER with Count>0:
  - Value <= Digits, with any same-cycle accepted digit included.
  - Commit_valid pulses the next cycle.
  - Digits, Count and Overflow clear.
- ENTER with Count=0 and no same-cycle accept: ignored, no pulse, Value held.
- CLR: Digits, Count and Overflow clear. Value is held.
- Priority:
  - CLR beats ENTER and beats a same-cycle accept; the accepted digit is dropped and no Key_valid is issued.
  - ENTER coinciding with accept: the digit is shifted in first, then committed. Key_valid and Commit_valid both pulse.
  - CLR and ENTER do not disturb the debounce FSM state.
- Reset mid-debounce or mid-hold: everything returns to reset values immediately. A key still held after reset release is debounced afresh and accepted once.
- db_cnt is sized clog2(DEBOUNCE_CYCLES+1) and saturates; it never wraps.

Test Plan (DEBOUNCE_CYCLES=4, NUM_DIGITS=4):
- Clean press: hold Bin=7, CHK=1 from edge 10 for 20 cycles, then release.
  - Required: Key_valid high exactly in the cycle after edge 15.
  - Required: Digits=0x0007, Count=1, and exactly one pulse.
- Bounce rejection: CHK toggles 1,0,1,0 every cycle with Bin=3, then goes stable 1.
  - Required: no pulse during toggling.
  - Required: one Key_valid 5 edges after the stable start, Digits[3:0]=3.
- Entry and commit: keys 1,2,0,5, then ENTER.
  - Required: Value=0x1205, Commit_valid one pulse, Count=0, Digits=0.
  - Required: ENTER again with Count=0 produces no pulse and Value stays 0x1205.
- Overflow: keys 1,2,3,4,5.
  - Required: Digits=0x2345, Count=4, Overflow=1.
  - Required: CLR gives Digits=0, Count=0, Overflow=0, and Value is unchanged.
- Invalid code: Bin=0xB held 10 cycles.
  - Required: Err one pulse, no Key_valid, buffer unchanged.
- Simultaneous events and reset:
  - ENTER on the accept cycle of key 9 with buffer 0x0004: required Value=0x0049.
  - CLR together with ENTER: required no Commit_valid and buffer cleared.
  - RST_N low during HELD with the key still held: required all outputs 0 and exactly one new accept after release of reset.

Source files
------------

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry: synchronizes and debounces the converter's key code,
// shifts accepted BCD digits into an entry buffer and commits it on ENTER.
module keypad_digit_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [3:0]                         Bin,
  input  logic                               CHK,
  input  logic                               CLR,
  input  logic                               ENTER,
  output logic [4*NUM_DIGITS-1:0]            Digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    Count,
  output logic [4*NUM_DIGITS-1:0]            Value,
  output logic                               Key_valid,
  output logic                               Commit_valid,
  output logic                               Overflow,
  output logic                               Err
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = 4 * NUM_DIGITS;

  localparam logic [DW-1:0] DB_TARGET = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_MAX    = {DW{1'b1}};
  localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Two-flop synchronizers for the asynchronous converter outputs
  logic       chk_s1_q, chk_s_q;
  logic [3:0] bin_s1_q, bin_s_q;

  // Debounce FSM state
  state_t        state_q, state_d;
  logic [3:0]    key_q, key_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [DW-1:0] db_cnt_inc;
  logic          accept;

  // Entry buffer and committed value
  logic [BW-1:0] digits_q, digits_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] value_q, value_d;
  logic          ovf_q, ovf_d;
  logic          key_valid_q, key_valid_d;
  logic          commit_valid_q, commit_valid_d;
  logic          err_q, err_d;

  logic [BW-1:0] digits_shift;
  logic          accept_digit;

  // Synchronizer flops: the FSM only ever looks at chk_s_q / bin_s_q
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chk_s1_q <= 1'b0;
      chk_s_q  <= 1'b0;
      bin_s1_q <= 4'd0;
      bin_s_q  <= 4'd0;
    end else begin
      chk_s1_q <= CHK;
      chk_s_q  <= chk_s1_q;
      bin_s1_q <= Bin;
      bin_s_q  <= bin_s1_q;
    end
  end

  // Saturating increment so the debounce counter can never wrap
  assign db_cnt_inc = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + DW'(1);

  // Debounce FSM next state; accept fires on the edge the count reaches target
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    db_cnt_d = db_cnt_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (chk_s_q) begin
          key_d    = bin_s_q;
          db_cnt_d = DW'(1);
          state_d  = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!chk_s_q || (bin_s_q != key_q)) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_inc;
          if (db_cnt_inc >= DB_TARGET) begin
            accept  = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        // Code changes while held are ignored: no auto-repeat
        if (!chk_s_q) begin
          db_cnt_d = DW'(1);
          state_d  = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (chk_s_q) begin
          state_d = HELD;
        end else begin
          db_cnt_d = db_cnt_inc;
          if (db_cnt_inc >= DB_TARGET) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Debounce FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      key_q    <= 4'd0;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Buffer shifted by one digit with the accepted key in the low nibble
  generate
    if (NUM_DIGITS == 1) begin : g_shift_one
      assign digits_shift = key_q;
    end else begin : g_shift_many
      assign digits_shift = {digits_q[BW-5:0], key_q};
    end
  endgenerate

  assign accept_digit = accept && (key_q <= 4'd9);

  // Buffer update: CLR wins over everything, then shift-in, then commit
  always_comb begin
    digits_d       = digits_q;
    count_d        = count_q;
    value_d        = value_q;
    ovf_d          = ovf_q;
    key_valid_d    = 1'b0;
    commit_valid_d = 1'b0;
    err_d          = accept && (key_q > 4'd9);
    if (CLR) begin
      digits_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (accept_digit) begin
        digits_d    = digits_shift;
        key_valid_d = 1'b1;
        if (count_q != CNT_FULL) begin
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      // The commit sees a same-cycle digit because digits_d already holds it
      if (ENTER && ((count_q != '0) || accept_digit)) begin
        value_d        = digits_d;
        commit_valid_d = 1'b1;
        digits_d       = '0;
        count_d        = '0;
        ovf_d          = 1'b0;
      end
    end
  end

  // Buffer, committed value and pulse registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digits_q       <= '0;
      count_q        <= '0;
      value_q        <= '0;
      ovf_q          <= 1'b0;
      key_valid_q    <= 1'b0;
      commit_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      digits_q       <= digits_d;
      count_q        <= count_d;
      value_q        <= value_d;
      ovf_q          <= ovf_d;
      key_valid_q    <= key_valid_d;
      commit_valid_q <= commit_valid_d;
      err_q          <= err_d;
    end
  end

  assign Digits       = digits_q;
  assign Count        = count_q;
  assign Value        = value_q;
  assign Key_valid    = key_valid_q;
  assign Commit_valid = commit_valid_q;
  assign Overflow     = ovf_q;
  assign Err          = err_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with DEBOUNCE_CYCLES=4, NUM_DIGITS=4.
module tb_keypad_digit_entry;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  Bin;
  logic        CHK;
  logic        CLR;
  logic        ENTER;
  logic [15:0] Digits;
  logic [2:0]  Count;
  logic [15:0] Value;
  logic        Key_valid;
  logic        Commit_valid;
  logic        Overflow;
  logic        Err;

  int total = 0;
  int bad   = 0;

  // Running pulse totals, sampled on the rising edge (pre-update values)
  int kv_cnt  = 0;
  int cv_cnt  = 0;
  int err_cnt = 0;
  int kv_base, cv_base, err_base;

  keypad_digit_entry #(
    .NUM_DIGITS(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .Bin(Bin),
    .CHK(CHK),
    .CLR(CLR),
    .ENTER(ENTER),
    .Digits(Digits),
    .Count(Count),
    .Value(Value),
    .Key_valid(Key_valid),
    .Commit_valid(Commit_valid),
    .Overflow(Overflow),
    .Err(Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (Key_valid)    kv_cnt  <= kv_cnt + 1;
    if (Commit_valid) cv_cnt  <= cv_cnt + 1;
    if (Err)          err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Clean press of one key followed by a full debounced release
  task automatic press_key(input logic [3:0] d);
    Bin = d;
    CHK = 1'b1;
    wait_cycles(10);
    CHK = 1'b0;
    wait_cycles(10);
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    wait_cycles(1);
    CLR = 1'b0;
    wait_cycles(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"},  32'(Digits), 32'h0);
    check({tag, "_count"},   32'(Count), 32'h0);
    check({tag, "_value"},   32'(Value), 32'h0);
    check({tag, "_kv"},      32'(Key_valid), 32'h0);
    check({tag, "_cv"},      32'(Commit_valid), 32'h0);
    check({tag, "_ovf"},     32'(Overflow), 32'h0);
    check({tag, "_err"},     32'(Err), 32'h0);
  endtask

  initial begin
    RST_N = 1'b0;
    Bin   = 4'd0;
    CHK   = 1'b0;
    CLR   = 1'b0;
    ENTER = 1'b0;
    wait_cycles(3);
    check_all_zero("reset");
    RST_N = 1'b1;
    wait_cycles(5);

    // Clean press: Key_valid must be visible exactly after edge k+5
    kv_base = kv_cnt;
    Bin = 4'd7;
    CHK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check($sformatf("clean_kv_edge%0d", i), 32'(Key_valid), (i == 5) ? 32'h1 : 32'h0);
    end
    wait_cycles(12);
    CHK = 1'b0;
    wait_cycles(10);
    check("clean_digits", 32'(Digits), 32'h0007);
    check("clean_count", 32'(Count), 32'h1);
    check("clean_pulses", 32'(kv_cnt - kv_base), 32'h1);

    // Bounce rejection, then a stable press with the same latency
    kv_base = kv_cnt;
    Bin = 4'd3;
    CHK = 1'b1; wait_cycles(1);
    CHK = 1'b0; wait_cycles(1);
    CHK = 1'b1; wait_cycles(1);
    CHK = 1'b0; wait_cycles(1);
    CHK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check($sformatf("bounce_kv_edge%0d", i), 32'(Key_valid), (i == 5) ? 32'h1 : 32'h0);
    end
    wait_cycles(4);
    CHK = 1'b0;
    wait_cycles(10);
    check("bounce_pulses", 32'(kv_cnt - kv_base), 32'h1);
    check("bounce_digits", 32'(Digits), 32'h0073);
    check("bounce_count", 32'(Count), 32'h2);

    // Entry and commit
    pulse_clr();
    cv_base = cv_cnt;
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd0);
    press_key(4'd5);
    check("entry_digits", 32'(Digits), 32'h1205);
    check("entry_count", 32'(Count), 32'h4);
    ENTER = 1'b1;
    wait_cycles(1);
    ENTER = 1'b0;
    check("commit_cv_now", 32'(Commit_valid), 32'h1);
    wait_cycles(3);
    check("commit_value", 32'(Value), 32'h1205);
    check("commit_pulses", 32'(cv_cnt - cv_base), 32'h1);
    check("commit_count", 32'(Count), 32'h0);
    check("commit_digits", 32'(Digits), 32'h0);
    ENTER = 1'b1;
    wait_cycles(1);
    ENTER = 1'b0;
    wait_cycles(3);
    check("empty_enter_pulses", 32'(cv_cnt - cv_base), 32'h1);
    check("empty_enter_value", 32'(Value), 32'h1205);

    // Overflow
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd3);
    press_key(4'd4);
    check("full_no_ovf", 32'(Overflow), 32'h0);
    press_key(4'd5);
    check("ovf_digits", 32'(Digits), 32'h2345);
    check("ovf_count", 32'(Count), 32'h4);
    check("ovf_flag", 32'(Overflow), 32'h1);
    pulse_clr();
    check("clr_digits", 32'(Digits), 32'h0);
    check("clr_count", 32'(Count), 32'h0);
    check("clr_ovf", 32'(Overflow), 32'h0);
    check("clr_value", 32'(Value), 32'h1205);

    // Invalid code with a non-empty buffer
    press_key(4'd4);
    kv_base  = kv_cnt;
    err_base = err_cnt;
    Bin = 4'hB;
    CHK = 1'b1;
    wait_cycles(10);
    CHK = 1'b0;
    wait_cycles(10);
    check("inv_err_pulses", 32'(err_cnt - err_base), 32'h1);
    check("inv_kv_pulses", 32'(kv_cnt - kv_base), 32'h0);
    check("inv_digits", 32'(Digits), 32'h0004);
    check("inv_count", 32'(Count), 32'h1);

    // ENTER on the accept cycle of key 9: shift first, then commit
    Bin = 4'd9;
    CHK = 1'b1;
    wait_cycles(5);
    ENTER = 1'b1;
    wait_cycles(1);
    ENTER = 1'b0;
    check("sim_kv", 32'(Key_valid), 32'h1);
    check("sim_cv", 32'(Commit_valid), 32'h1);
    check("sim_value", 32'(Value), 32'h0049);
    check("sim_digits", 32'(Digits), 32'h0);
    check("sim_count", 32'(Count), 32'h0);
    wait_cycles(6);
    CHK = 1'b0;
    wait_cycles(10);

    // CLR together with ENTER: no commit, buffer cleared
    press_key(4'd8);
    check("clrent_pre_digits", 32'(Digits), 32'h0008);
    cv_base = cv_cnt;
    CLR   = 1'b1;
    ENTER = 1'b1;
    wait_cycles(1);
    CLR   = 1'b0;
    ENTER = 1'b0;
    wait_cycles(3);
    check("clrent_cv_pulses", 32'(cv_cnt - cv_base), 32'h0);
    check("clrent_digits", 32'(Digits), 32'h0);
    check("clrent_count", 32'(Count), 32'h0);
    check("clrent_value", 32'(Value), 32'h0049);

    // Reset while a key is held, then one fresh accept after release of reset
    Bin = 4'd2;
    CHK = 1'b1;
    wait_cycles(10);
    check("held_digits", 32'(Digits), 32'h0002);
    #2 RST_N = 1'b0;
    #1 check_all_zero("midreset");
    wait_cycles(3);
    RST_N = 1'b1;
    kv_base = kv_cnt;
    wait_cycles(15);
    check("rst_reaccept_pulses", 32'(kv_cnt - kv_base), 32'h1);
    check("rst_reaccept_digits", 32'(Digits), 32'h0002);
    check("rst_reaccept_count", 32'(Count), 32'h1);
    check("rst_reaccept_value", 32'(Value), 32'h0);
    CHK = 1'b0;
    wait_cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
